// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch: sequencing stage in front of the 16-bit combinational ALU.
// Accepts one opcode plus operands over valid/ready, drives registered ALU strobes
// and operands for one cycle (MUL_CYCLES for multiply), captures sum/cout/z and
// returns the result over a second valid/ready handshake. One op in flight.
// Optional: define ALU_DISPATCH_STICKY_FLAGS_EN for sticky carry/zero flags.
module alu_op_dispatch #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
`ifdef ALU_DISPATCH_STICKY_FLAGS_EN
   input  logic             flags_clr,
   output logic             sticky_c,
   output logic             sticky_z,
`endif
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_subtract,
   output logic             alu_mult,
   output logic             alu_and,
   output logic             alu_or,
   output logic             alu_xor,
   output logic             alu_not,
   output logic             alu_half_mode,
   output logic             alu_bytewise_mode,
   output logic             alu_l_shift,
   output logic             alu_r_shift,
   input  logic [WIDTH-1:0] alu_sum,
   input  logic             alu_cout,
   input  logic             alu_z,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_cout,
   output logic             res_z,
   output logic             res_illegal,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StExec, StMulWait, StDone} state_e;

   // Strobe vector bit positions, MSB first: sub mult and or xor not half byte lsl lsr
   localparam logic [9:0] SSub  = 10'b10_0000_0000;
   localparam logic [9:0] SMul  = 10'b01_0000_0000;
   localparam logic [9:0] SAnd  = 10'b00_1000_0000;
   localparam logic [9:0] SOr   = 10'b00_0100_0000;
   localparam logic [9:0] SXor  = 10'b00_0010_0000;
   localparam logic [9:0] SNot  = 10'b00_0001_0000;
   localparam logic [9:0] SHalf = 10'b00_0000_1000;
   localparam logic [9:0] SByte = 10'b00_0000_0100;
   localparam logic [9:0] SLsl  = 10'b00_0000_0010;
   localparam logic [9:0] SLsr  = 10'b00_0000_0001;

   localparam logic [3:0] OpMul   = 4'h3;
   localparam logic [3:0] CntInit = 4'(MUL_CYCLES - 1);

   state_e     state;
   logic [3:0] cnt;
   logic [9:0] strb;

   // Opcode to strobe set; plain ADD and illegal codes map to no strobes.
   function automatic logic [9:0] decode(input logic [3:0] code);
      logic [9:0] s;
      s = '0;
      case (code)
         4'h1:    s = SHalf;
         4'h2:    s = SSub;
         4'h3:    s = SMul;
         4'h4:    s = SAnd;
         4'h5:    s = SOr;
         4'h6:    s = SXor;
         4'h7:    s = SNot;
         4'h8:    s = SAnd | SByte;
         4'h9:    s = SOr  | SByte;
         4'hA:    s = SXor | SByte;
         4'hB:    s = SNot | SByte;
         4'hC:    s = SLsl;
         4'hD:    s = SLsr;
         default: s = '0;
      endcase
      return s;
   endfunction

   assign {alu_subtract, alu_mult, alu_and, alu_or, alu_xor, alu_not,
           alu_half_mode, alu_bytewise_mode, alu_l_shift, alu_r_shift} = strb;

   // Dispatch FSM; every output is a register so strobes cannot glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         cnt         <= '0;
         strb        <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         op_ready    <= 1'b1;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_cout    <= 1'b0;
         res_z       <= 1'b0;
         res_illegal <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (op_valid && op_ready) begin
                  alu_a    <= op_a;
                  alu_b    <= op_b;
                  op_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (op_code >= 4'hE) begin
                     // Illegal codes never touch the ALU.
                     state       <= StDone;
                     res_valid   <= 1'b1;
                     res_data    <= '0;
                     res_cout    <= 1'b0;
                     res_z       <= 1'b0;
                     res_illegal <= 1'b1;
                  end else if (op_code == OpMul) begin
                     state <= StMulWait;
                     cnt   <= CntInit;
                     strb  <= decode(op_code);
                  end else begin
                     state <= StExec;
                     strb  <= decode(op_code);
                  end
               end
            end
            StExec: begin
               state       <= StDone;
               strb        <= '0;
               res_valid   <= 1'b1;
               res_data    <= alu_sum;
               res_cout    <= alu_cout;
               res_z       <= alu_z;
               res_illegal <= 1'b0;
            end
            StMulWait: begin
               if (cnt == 4'd0) begin
                  state       <= StDone;
                  strb        <= '0;
                  res_valid   <= 1'b1;
                  res_data    <= alu_sum;
                  res_cout    <= alu_cout;
                  res_z       <= alu_z;
                  res_illegal <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            StDone: begin
               // op_ready returns one cycle after consumption, so no overlap.
               if (res_ready) begin
                  state     <= StIdle;
                  res_valid <= 1'b0;
                  op_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef ALU_DISPATCH_STICKY_FLAGS_EN
   logic capture;
   assign capture = (state == StExec) || ((state == StMulWait) && (cnt == 4'd0));

   // Sticky flags accumulate legal captures; clear beats a same-cycle capture.
   always_ff @(posedge clk) begin
      if (reset || flags_clr) begin
         sticky_c <= 1'b0;
         sticky_z <= 1'b0;
      end else if (capture) begin
         sticky_c <= sticky_c | alu_cout;
         sticky_z <= sticky_z | alu_z;
      end
   end
`endif

endmodule

// File: doc/alu_op_dispatch.md
Name: alu_op_dispatch

Overview:
Sequencing stage wrapped around the 16-bit combinational ALU. It accepts an encoded opcode and two operands over a valid/ready handshake. It drives the ALU's one-hot control strobes and operand inputs for the required number of cycles, captures sum/cout/z, and presents the result downstream over a second valid/ready handshake. It holds exactly one operation in flight.

Parameters:
WIDTH, 16, operand/result width; must match ALU width
MUL_CYCLES, 2, cycles ALU inputs are held stable for multiply before capture; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  upstream request valid
op_ready  out  1  stage can accept a request
op_code  in  4  operation select (encoding below)
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_subtract, alu_mult, alu_and, alu_or, alu_xor, alu_not, alu_half_mode, alu_bytewise_mode, alu_l_shift, alu_r_shift  out  1 each  ALU control strobes
alu_sum  in  WIDTH  ALU result
alu_cout  in  1  ALU carry
alu_z  in  1  ALU zero
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  captured result
res_cout  out  1  captured carry
res_z  out  1  captured zero
res_illegal  out  1  result is from an illegal opcode
busy  out  1  high in any state except IDLE

Behaviour:
- Opcode encoding:
  - 0 ADD, 1 ADDH (half_mode), 2 SUB, 3 MUL
  - 4 AND, 5 OR, 6 XOR, 7 NOT
  - 8 ANDB, 9 ORB, A XORB, B NOTB (logical op with bytewise_mode)
  - C LSL, D LSR
  - E and F are illegal.
- FSM states: IDLE, EXEC, MULWAIT, DONE. Reset places the FSM in IDLE. All outputs reset to 0, with op_ready=1.
- IDLE:
  - op_ready=1; all strobes low; alu_a/alu_b hold their last values.
  - On op_valid&op_ready, op_code/op_a/op_b are registered.
  - Legal non-MUL opcode goes to EXEC. MUL goes to MULWAIT with counter=MUL_CYCLES-1. Illegal opcode goes directly to DONE with res_data=0, res_cout=0, res_z=0, res_illegal=1, and no strobes asserted.
- EXEC:
  - Lasts exactly 1 cycle. Registered operands drive alu_a/alu_b; exactly the decoded strobes are high.
  - At the clock edge, alu_sum/alu_cout/alu_z are captured into res_* with res_illegal=0. Next state is DONE.
- MULWAIT:
  - alu_mult is high and operands are held.
  - The counter decrements each cycle. When counter==0, results are captured and the FSM goes to DONE. With MUL_CYCLES=1, MULWAIT lasts exactly 1 cycle.
- DONE:
  - res_valid=1; res_* are stable; strobes are low; op_ready=0.
  - On res_ready the FSM returns to IDLE, and op_ready=1 on the following cycle. Request-to-result latency is 2 cycles for non-MUL and 1+MUL_CYCLES cycles for MUL.
- No overlap: a new request is never accepted in the same cycle a result is consumed. Throughput is at most one op per 3 cycles.
- All strobes are registered outputs, never more than one operation group at a time, and glitch-free.
- Synchronous reset in any state, including mid-MULWAIT: next cycle in IDLE, res_valid=0, the in-flight op is discarded, and no result is emitted.
- res_* values persist after consumption until the next capture.

Optional Feature:
- Macro: ALU_DISPATCH_STICKY_FLAGS_EN.
- When defined:
  - Adds input flags_clr (1) and outputs sticky_c (1) and sticky_z (1).
  - Each legal capture ORs res_cout into sticky_c and res_z into sticky_z.
  - flags_clr synchronously clears both. If flags_clr and a capture occur in the same cycle, the clear wins and the captured values are discarded from the sticky bits.
  - Reset clears both.
- When undefined: these ports do not exist and there is no added logic.

Test Plan:
- Use a behavioural ALU model on the bench. ADD a=2556, b=44433 -> res_valid 2 cycles after accept; res_data=46989, res_cout=0, res_z=0; only alu_* strobes all low except none (plain add).
- SUB a=44433, b=2556 -> res_data=41877, alu_subtract high for exactly 1 cycle. MUL a=212, b=102 with MUL_CYCLES=2 -> alu_mult high 2 cycles, res_data=21624, latency 3.
- AND a=0xA5C3, b=0xF05A -> 0xA042. NOT a=0xFFFF -> res_data=0, res_z=1. XORB a=0xA5C3 -> alu_xor and alu_bytewise_mode both high for 1 cycle.
- op_code=0xE -> DONE next cycle; res_illegal=1, res_data=0; no ALU strobe ever asserted.
- Hold res_ready=0 for 5 cycles after result -> res_* stable, op_ready=0, a second op_valid is not accepted. Raise res_ready -> IDLE, then the second op is accepted.
- Assert reset during cycle 2 of MULWAIT (MUL_CYCLES=4) -> next cycle IDLE, op_ready=1, res_valid never asserts. A subsequent ADD 1+1 -> res_data=2.
